// File: rtl/iob_integ_pkg.sv
// Shared defaults for the streaming integrator slice.
package iob_integ_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/iob_integ_if.sv
// Valid/ready stream bundle for the integrator: difference samples in, running sum out.
interface iob_integ_if
  import iob_integ_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic              load_i;
  logic [DATA_W-1:0] data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  count_o;

  // Integrator side
  modport slave (
    input  in_valid_i, load_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, count_o
  );

  // Producer/consumer side
  modport master (
    output in_valid_i, load_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, count_o
  );

endinterface

// File: rtl/iob_integ_core.sv
// Next-state datapath: wrap-around accumulate or load, and sample counter.
module iob_integ_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] sample,
  input  logic              load,
  input  logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] acc_nxt_c,
  output logic [CNT_W-1:0]  count_nxt_c
);

  // Carry out is dropped on purpose so the sum wraps modulo 2^DATA_W
  always_comb begin
    acc_nxt_c   = acc + sample;
    count_nxt_c = count + CNT_W'(1);
    if (load) begin
      acc_nxt_c   = sample;
      count_nxt_c = CNT_W'(1);
    end
  end

endmodule

// File: rtl/iob_reg_r.sv
// Register cell with async reset, clock enable, sync clear and load enable.
module iob_reg_r #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         cke_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Clear has priority over load; nothing moves while the clock enable is low
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      q_o <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        q_o <= RST_VAL;
      end else if (en_i) begin
        q_o <= d_i;
      end
    end
  end

endmodule

// File: rtl/iob_integ.sv
// Streaming integrator: running sum of difference samples, one-entry output stage.
module iob_integ
  import iob_integ_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned       CNT_W   = CNT_W_DEF
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        cke_i,
  input  logic        rst_i,
  iob_integ_if.slave  bus
);

  logic              in_ready;
  logic              in_fire;
  logic              out_fire;
  logic              out_valid;
  logic              valid_en;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  // Handshake: accept when the output slot is empty or being drained this cycle
  assign in_ready = cke_i & ~rst_i & (~out_valid | bus.out_ready_i);
  assign in_fire  = bus.in_valid_i & in_ready;
  assign out_fire = out_valid & bus.out_ready_i & cke_i;
  assign valid_en = in_fire | out_fire;

  iob_integ_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .acc         (acc),
    .sample      (bus.data_i),
    .load        (bus.load_i),
    .count       (count),
    .acc_nxt_c   (acc_nxt),
    .count_nxt_c (count_nxt)
  );

  // Accumulator doubles as the output data register
  iob_reg_r #(
    .W       (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_acc_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (in_fire),
    .d_i    (acc_nxt),
    .q_o    (acc)
  );

  // Output valid: set on accept, cleared on drain without a refill
  iob_reg_r #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_valid_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (valid_en),
    .d_i    (in_fire),
    .q_o    (out_valid)
  );

  // Samples accepted since the last reset, clear or load
  iob_reg_r #(
    .W       (CNT_W),
    .RST_VAL ('0)
  ) u_count_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (in_fire),
    .d_i    (count_nxt),
    .q_o    (count)
  );

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.data_o      = acc;
  assign bus.count_o     = count;

endmodule

// File: tb/tb_iob_integ.sv
// Self-checking bench for iob_integ: directed cases plus a difference/integrate round trip.
module tb_iob_integ;

  localparam int unsigned   DW = 32;
  localparam int unsigned   CW = 16;
  localparam logic [DW-1:0] RV = '0;
  localparam int            N_RT = 1000;

  logic clk = 1'b0;
  logic arst;
  logic cke;
  logic rst;

  iob_integ_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  iob_integ #(
    .DATA_W  (DW),
    .RST_VAL (RV),
    .CNT_W   (CW)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .cke_i  (cke),
    .rst_i  (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state and scoreboards
  logic [DW-1:0] m_acc;
  logic [CW-1:0] m_cnt;
  logic          m_valid;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] xq[$];
  bit            rt_mode;
  logic [DW-1:0] cur_x;
  bit            fired;
  logic [DW-1:0] x[N_RT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs at the falling edge, advance the model
  task automatic drive(input logic c, input logic r, input logic v, input logic l,
                       input logic [DW-1:0] d, input logic ordy);
    logic exp_rdy;
    logic ofire;
    cke              = c;
    rst              = r;
    bus.in_valid_i   = v;
    bus.load_i       = l;
    bus.data_i       = d;
    bus.out_ready_i  = ordy;
    @(negedge clk);
    exp_rdy = c & ~r & (~m_valid | ordy);
    check("in_ready", 64'(bus.in_ready_o), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid_o), 64'(m_valid));
    check("count", 64'(bus.count_o), 64'(m_cnt));
    check("data", 64'(bus.data_o), 64'(m_acc));
    ofire = m_valid & ordy & c;
    fired = v & exp_rdy;
    if (ofire) begin
      if (sb.size() == 0) check("sb_size", 64'(sb.size()), 64'd1);
      else check("sb_data", 64'(bus.data_o), 64'(sb.pop_front()));
      if (rt_mode) begin
        if (xq.size() == 0) check("rt_size", 64'(xq.size()), 64'd1);
        else check("rt_data", 64'(bus.data_o), 64'(xq.pop_front()));
      end
    end
    if (c) begin
      if (r) begin
        m_acc   = RV;
        m_cnt   = '0;
        m_valid = 1'b0;
        sb.delete();
      end else if (fired) begin
        m_acc   = l ? d : DW'(m_acc + d);
        m_cnt   = l ? CW'(1) : CW'(m_cnt + CW'(1));
        m_valid = 1'b1;
        sb.push_back(m_acc);
        if (rt_mode) xq.push_back(cur_x);
      end else if (ofire) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] c,
                            input logic v);
    check({tag, "_data"}, 64'(bus.data_o), 64'(d));
    check({tag, "_cnt"}, 64'(bus.count_o), 64'(c));
    check({tag, "_vld"}, 64'(bus.out_valid_o), 64'(v));
  endtask

  initial begin
    int idx;
    int budget;
    logic [DW-1:0] prev;

    arst = 1'b1;
    cke = 1'b1;
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.load_i = 1'b0;
    bus.data_i = '0;
    bus.out_ready_i = 1'b1;
    m_acc = RV;
    m_cnt = '0;
    m_valid = 1'b0;
    rt_mode = 1'b0;
    cur_x = '0;

    // Async reset state
    repeat (2) @(negedge clk);
    expect_out("rst", RV, '0, 1'b0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // Basic accumulation including a negative step
    drive(1, 0, 1, 0, 32'd5, 1);
    expect_out("seq0", 32'd5, 16'd1, 1'b1);
    drive(1, 0, 1, 0, 32'd3, 1);
    expect_out("seq1", 32'd8, 16'd2, 1'b1);
    drive(1, 0, 1, 0, 32'hFFFF_FFFE, 1);
    expect_out("seq2", 32'd6, 16'd3, 1'b1);
    drive(1, 0, 0, 0, '0, 1);
    expect_out("idle", 32'd6, 16'd3, 1'b0);

    // Load then wrap past 2^32
    drive(1, 0, 1, 1, 32'hFFFF_FFF0, 1);
    expect_out("load", 32'hFFFF_FFF0, 16'd1, 1'b1);
    drive(1, 0, 1, 0, 32'h20, 1);
    expect_out("wrap", 32'h10, 16'd2, 1'b1);

    // Backpressure holds the result and blocks input
    drive(1, 0, 1, 0, 32'd1, 1);
    expect_out("bp0", 32'h11, 16'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 32'd9, 0);
      expect_out("bp_hold", 32'h11, 16'd3, 1'b1);
      check("bp_rdy", 64'(bus.in_ready_o), 64'd0);
    end
    drive(1, 0, 1, 0, 32'd9, 1);
    expect_out("bp_rel", 32'h1A, 16'd4, 1'b1);
    drive(1, 0, 0, 0, '0, 1);
    expect_out("bp_drain", 32'h1A, 16'd4, 1'b0);

    // Clear wins over a valid sample
    drive(1, 0, 1, 1, 32'd100, 1);
    expect_out("clr_ld", 32'd100, 16'd1, 1'b1);
    drive(1, 1, 1, 0, 32'd7, 1);
    expect_out("clr", RV, '0, 1'b0);
    drive(1, 0, 1, 0, 32'd7, 1);
    expect_out("clr_nxt", RV + 32'd7, 16'd1, 1'b1);

    // Clock enable low freezes everything, including the sync clear
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 2), 1, 0, 32'd5, 1);
      expect_out("cke_frz", RV + 32'd7, 16'd1, 1'b1);
      check("cke_rdy", 64'(bus.in_ready_o), 64'd0);
    end
    drive(1, 0, 1, 0, 32'd5, 1);
    expect_out("cke_res", RV + 32'd12, 16'd2, 1'b1);

    // Round trip: original sequence -> difference -> integrator
    drive(1, 1, 0, 0, '0, 1);
    for (int i = 0; i < N_RT; i++) begin
      x[i] = (i % 7 == 0) ? DW'($urandom) : DW'(x[(i == 0) ? 0 : i - 1] + DW'($urandom_range(0, 15)) - DW'(8));
    end
    rt_mode = 1'b1;
    idx = 0;
    budget = 0;
    prev = RV;
    while (idx < N_RT && budget < 20000) begin
      cur_x = x[idx];
      drive(1, 0, ($urandom_range(0, 3) != 0), 0, DW'(x[idx] - prev), ($urandom_range(0, 3) != 0));
      if (fired) begin
        prev = x[idx];
        idx++;
      end
      budget++;
    end
    check("rt_done", 64'(idx), 64'(N_RT));
    repeat (3) drive(1, 0, 0, 0, '0, 1);
    check("rt_left", 64'(xq.size()), 64'd0);
    check("rt_cnt", 64'(bus.count_o), 64'(CW'(N_RT)));
    rt_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
